// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Writeback arbiter for the 32x32 single-write-port integer register file.
// Two sources compete for the write port: req0 (execute unit) and req1
// (load/store unit). One of them is granted per cycle by round-robin. The
// winning write is registered and drives the register file one cycle later.
//
// Optional feature (macro WB_SCOREBOARD_EN): a busy-bit scoreboard that
// tracks in-flight destination registers so decode can stall on RAW hazards.
// Without the macro, no busy register is built, busy_vec/chk_stall read 0,
// and the issue/check inputs are ignored.
//
// Ports:
//   clk, rst                    clock; synchronous active-high reset
//   req0_valid/ready/addr/data  EXU writeback request and accept
//   req1_valid/ready/addr/data  LSU writeback request and accept
//   rf_wen/rf_waddr/rf_wdata    registered register file write port
//   issue_valid, issue_rd       destination register of an issuing instruction
//   chk_rs1, chk_rs2            source registers of the instruction in decode
//   chk_stall                   a source register is busy (combinational)
//   busy_vec                    scoreboard busy bits, bit i = register i
//   wb_count                    count of committed non-x0 writes (wraps)

module regfile_wb_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [AW-1:0]   req0_addr,
    input  logic [XLEN-1:0] req0_data,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [AW-1:0]   req1_addr,
    input  logic [XLEN-1:0] req1_data,

    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,

    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    output logic            chk_stall,
    output logic [31:0]     busy_vec,
    output logic [31:0]     wb_count
);

    // Last requester served; 1 out of reset so req0 wins the first contention.
    logic            last_grant_q;
    logic            gnt0;
    logic            gnt1;
    logic            xfer;
    logic [AW-1:0]   xfer_addr;
    logic [XLEN-1:0] xfer_data;

    logic            wen_q;
    logic [AW-1:0]   waddr_q;
    logic [XLEN-1:0] wdata_q;
    logic [31:0]     count_q;

    // Arbitration depends only on valids and last_grant, never on the other
    // requester's addr/data. Grants are suppressed while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // A grant is only ever given to a valid requester, so grant == transfer.
    assign xfer      = gnt0 | gnt1;
    assign xfer_addr = gnt1 ? req1_addr : req0_addr;
    assign xfer_data = gnt1 ? req1_data : req0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            count_q      <= '0;
        end else begin
            // x0 writes are accepted but never reach the register file.
            wen_q <= xfer && (xfer_addr != '0);
            if (xfer) begin
                last_grant_q <= gnt1;
                waddr_q      <= xfer_addr;
                wdata_q      <= xfer_data;
            end
            if (wen_q) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // Outputs read as reset values while rst is high, so a write held in the
    // output register is dropped immediately rather than one cycle late.
    assign rf_wen   = wen_q & ~rst;
    assign rf_waddr = rst ? '0 : waddr_q;
    assign rf_wdata = rst ? '0 : wdata_q;
    assign wb_count = rst ? '0 : count_q;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_q;
    logic [31:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (wen_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        // Set after clear: a newer producer of the same register is in flight.
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // No bypass of a same-cycle clear: the stall uses the registered bits.
    assign chk_stall = ~rst & (busy_q[chk_rs1] | busy_q[chk_rs2]);
    assign busy_vec  = rst ? '0 : busy_q;
`else
    logic unused_sb;
    assign unused_sb = ^{issue_valid, issue_rd, chk_rs1, chk_rs2};

    assign chk_stall = 1'b0;
    assign busy_vec  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        chk_stall;
    logic [31:0] busy_vec;
    logic [31:0] wb_count;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_arbiter #(
        .XLEN (32),
        .AW   (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .chk_stall   (chk_stall),
        .busy_vec    (busy_vec),
        .wb_count    (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next active edge; inputs are then driven well away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        req0_valid  = 1'b1;
        req0_addr   = 5'd1;
        req0_data   = 32'h0000_00A0;
        req1_valid  = 1'b1;
        req1_addr   = 5'd2;
        req1_data   = 32'h0000_00B1;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        chk_rs1     = 5'd7;
        chk_rs2     = 5'd0;

        // Reset held for two cycles with requests and an issue pending.
        for (int i = 0; i < 2; i++) begin
            #1;
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
            check("rst_wen", rf_wen, 0);
            check("rst_waddr", rf_waddr, 0);
            check("rst_wdata", rf_wdata, 0);
            check("rst_busy", busy_vec, 0);
            check("rst_count", wb_count, 0);
            check("rst_stall", chk_stall, 0);
            step();
        end

        // Contention: both valid for 6 cycles, grants 0,1,0,1,0,1.
        rst         = 1'b0;
        issue_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("cont_ready0", req0_ready, (i % 2 == 0));
            check("cont_ready1", req1_ready, (i % 2 == 1));
            if (i == 0) begin
                check("cont_busy_after_rst", busy_vec, 0);
            end else begin
                check("cont_wen", rf_wen, 1);
                check("cont_waddr", rf_waddr, ((i - 1) % 2 == 0) ? 1 : 2);
                check("cont_wdata", rf_wdata, ((i - 1) % 2 == 0) ? 32'hA0 : 32'hB1);
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("cont_last_wen", rf_wen, 1);
        check("cont_last_waddr", rf_waddr, 2);
        check("cont_count5", wb_count, 5);
        step();

        // Single write from req0.
        #1;
        check("idle_wen", rf_wen, 0);
        check("idle_waddr_hold", rf_waddr, 2);
        check("cont_count6", wb_count, 6);
        req0_valid = 1'b1;
        req0_addr  = 5'd5;
        req0_data  = 32'hDEAD_BEEF;
        #1;
        check("single_ready0", req0_ready, 1);
        check("single_ready1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        #1;
        check("single_wen", rf_wen, 1);
        check("single_waddr", rf_waddr, 5);
        check("single_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("single_count_pre", wb_count, 6);
        step();

        // x0 write from req1.
        #1;
        check("single_count", wb_count, 7);
        check("single_wen_off", rf_wen, 0);
        req1_valid = 1'b1;
        req1_addr  = 5'd0;
        req1_data  = 32'h0000_1234;
        #1;
        check("x0_ready1", req1_ready, 1);
        check("x0_ready0", req0_ready, 0);
        step();
        req1_valid = 1'b0;
        #1;
        check("x0_wen", rf_wen, 0);
        check("x0_waddr", rf_waddr, 0);
        check("x0_wdata", rf_wdata, 32'h1234);
        step();
        #1;
        check("x0_count", wb_count, 7);

        // Scoreboard.
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        chk_rs1     = 5'd7;
        chk_rs2     = 5'd0;
        #1;
        check("sb_stall_pre", chk_stall, 0);
        step();
        issue_valid = 1'b0;
`ifdef WB_SCOREBOARD_EN
        #1;
        check("sb_busy_set", busy_vec, 32'h0000_0080);
        check("sb_stall_rs1", chk_stall, 1);
        chk_rs1 = 5'd3;
        chk_rs2 = 5'd7;
        #1;
        check("sb_stall_rs2", chk_stall, 1);
        chk_rs1 = 5'd7;
        chk_rs2 = 5'd0;
        req0_valid = 1'b1;
        req0_addr  = 5'd7;
        req0_data  = 32'h77;
        #1;
        check("sb_ready0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        #1;
        check("sb_commit_wen", rf_wen, 1);
        check("sb_busy_commit", busy_vec, 32'h0000_0080);
        step();
        #1;
        check("sb_busy_clear", busy_vec, 0);
        check("sb_stall_clear", chk_stall, 0);

        // Re-issue rd=7 in the commit cycle of a write to 7: bit stays set.
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        req0_valid  = 1'b1;
        #1;
        check("sb_reissue_busy", busy_vec, 32'h0000_0080);
        step();
        req0_valid  = 1'b0;
        issue_valid = 1'b1;
        #1;
        check("sb_commit2_wen", rf_wen, 1);
        step();
        issue_valid = 1'b0;
        #1;
        check("sb_set_wins", busy_vec, 32'h0000_0080);
`else
        #1;
        check("nosb_busy", busy_vec, 0);
        check("nosb_stall", chk_stall, 0);
`endif

        // Reset mid-flight.
        req0_valid  = 1'b1;
        req0_addr   = 5'd3;
        req0_data   = 32'h33;
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        #1;
        check("mid_ready0", req0_ready, 1);
        step();
        req0_valid  = 1'b0;
        issue_valid = 1'b0;
        rst         = 1'b1;
        #1;
        check("mid_wen_dropped", rf_wen, 0);
        check("mid_waddr", rf_waddr, 0);
        step();
        rst = 1'b0;
        #1;
        check("mid_wen_after", rf_wen, 0);
        check("mid_busy", busy_vec, 0);
        check("mid_count", wb_count, 0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_addr  = 5'd4;
        req1_addr  = 5'd6;
        #1;
        check("mid_ready0_wins", req0_ready, 1);
        check("mid_ready1_loses", req1_ready, 0);
        step();
        #1;
        check("mid_ready1_next", req1_ready, 1);
        check("mid_waddr_next", rf_waddr, 4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter and scoreboard for the 32×32 single-write-port integer register file. Two writeback sources compete for the one write port: req0, the execute unit, and req1, the load/store unit. The block grants one of them per cycle by round-robin, registers the winning write, and drives the register file write port one cycle later. An optional busy-bit scoreboard tracks in-flight destination registers so the decode stage can stall on RAW hazards.

## Interface
- XLEN, 32, data width of a register write
- AW, 5, register address width (32 registers; x0 hardwired zero)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req0_valid  in  1  EXU writeback request
- req0_ready  out  1  EXU request accepted this cycle
- req0_addr  in  AW  EXU destination register
- req0_data  in  XLEN  EXU write data
- req1_valid / req1_ready / req1_addr / req1_data  same as req0, for the LSU
- rf_wen  out  1  register file write enable (registered)
- rf_waddr  out  AW  register file write address (registered)
- rf_wdata  out  XLEN  register file write data (registered)
- issue_valid  in  1  an instruction with a destination register issues this cycle
- issue_rd  in  AW  destination register of the issuing instruction
- chk_rs1, chk_rs2  in  AW  source registers of the instruction in decode
- chk_stall  out  1  a source register is busy (combinational)
- busy_vec  out  32  scoreboard busy bits, bit i = register i
- wb_count  out  32  count of committed non-x0 writes

## Operation
- **Grant state.** `last_grant` is a 1-bit register recording the last requester served.
- **Arbitration (combinational).**
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester other than `last_grant`.
  - Neither valid: no grant, `last_grant` holds.
- **Ready.** `reqN_ready` = grant to N. At most one ready is high per cycle. Ready never depends on the other requester's data.
- **Handshake.**
  - A transfer happens when valid && ready.
  - A requester must hold valid, addr and data stable until its transfer.
  - On a transfer, `last_grant` is set to N.
- **Output register.** Loaded every cycle.
  - `rf_wen` = transfer && addr != 0.
  - `rf_waddr` and `rf_wdata` take the granted request's addr and data on a transfer; they hold otherwise.
  - A write to x0 is accepted (ready high) but produces no write and no scoreboard clear.
- **Commit counter.** `wb_count` increments by 1 on every cycle with `rf_wen` = 1. It wraps from 0xFFFFFFFF to 0.
- **Scoreboard.**
  - Set: `issue_valid` && `issue_rd` != 0 sets `busy[issue_rd]` at the next edge.
  - Clear: `busy[rf_waddr]` clears at the next edge while `rf_wen` = 1, i.e. the commit cycle.
  - Set and clear of the same index in one cycle: set wins, because a newer producer is in flight.
  - Bit 0 is always 0.
  - `chk_stall` = `busy[chk_rs1]` | `busy[chk_rs2]`, using the current register values with no bypass of a same-cycle clear.

## Timing
- **Reset values.** While `rst` = 1 and on the edge it is sampled:
  - `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0
  - `last_grant`=1, so req0 wins the first contention
  - `busy_vec`=0, `wb_count`=0
  - `req0_ready`=`req1_ready`=0, `chk_stall`=0
- **Reset mid-operation.** A write held in the output register is dropped (`rf_wen` forced 0). The requester that was handshaking must re-present after reset.
- **Latency.**
  - Handshake in cycle T → `rf_wen` high in T+1 → register file updated at the end of T+1.
  - Busy bit clears visibly in T+2.
- **Throughput.**
  - One write per cycle.
  - With both requesters continuously valid, grants alternate every cycle; each requester waits at most 1 cycle.
- **Readiness.** Ready is combinational from valid and `last_grant`; there is no ready→valid combinational path.

## Configuration
- **`WB_SCOREBOARD_EN` defined:** scoreboard implemented exactly as described above.
- **`WB_SCOREBOARD_EN` undefined:**
  - No busy register is built.
  - `busy_vec` is tied to 0 and `chk_stall` is tied to 0.
  - `issue_valid`, `issue_rd`, `chk_rs1` and `chk_rs2` are ignored.
  - Arbitration, output register and `wb_count` are unchanged.

## Test plan
- **Reset:** assert `rst` 2 cycles → every output reads 0; then `req0_valid`=`req1_valid`=1 in the same cycle → `req0_ready`=1 and `req1_ready`=0 (req0 wins).
- **Single write:** req0 addr=5, data=0xDEADBEEF in cycle T → in T+1, `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF; `wb_count`=1 in T+2.
- **Contention:** both requesters valid for 6 cycles, req0 addr=1, req1 addr=2 → grants alternate 0,1,0,1,0,1; the `rf_waddr` sequence is 1,2,1,2,1,2.
- **x0 write:** req1 addr=0, data=0x1234 → `req1_ready`=1; next cycle `rf_wen`=0 and `wb_count` unchanged.
- **Scoreboard (macro defined):**
  - Issue rd=7 → `busy_vec[7]`=1 next cycle; `chk_rs1`=7 gives `chk_stall`=1.
  - req0 writes addr 7 → bit 7 clears 2 cycles after the handshake.
  - Issue rd=7 in the commit cycle → bit stays 1.
- **Reset mid-flight:** handshake req0 addr=3 in T, `rst`=1 in T+1 → `rf_wen`=0 in T+1; `busy_vec`=0 and `wb_count`=0 afterward.
